// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, h/v position
// counters and a registered decode of syncs, blanking, coordinates and
// line/frame strobes. All decoded outputs are computed from the next
// position so they change on the same edge as the counters.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int PIX_DIV    = 2,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          h_sync,
  output logic          v_sync,
  output logic          blank_n,
  output logic [CW-1:0] posx,
  output logic [CW-1:0] posy,
  output logic          pix_stb,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      PIX_DIV < 1 || H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_ACT    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] H_SS     = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] H_SE     = CW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] V_SE     = CW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic          tick;
  logic          h_sync_q, h_sync_d, v_sync_q, v_sync_d, blank_q, blank_d;
  logic [CW-1:0] posx_q, posx_d, posy_q, posy_d;
  logic          pix_stb_q, line_q, line_d, frame_q, frame_d;

  // Next position and its decode; everything here is consumed on a tick.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
    blank_d  = (hc_d < H_ACT) && (vc_d < V_ACT);
    posx_d   = blank_d ? hc_d : '0;
    posy_d   = blank_d ? vc_d : '0;
    h_sync_d = (hc_d >= H_SS && hc_d < H_SE) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d = (vc_d >= V_SS && vc_d < V_SE) ? V_SYNC_POL : ~V_SYNC_POL;
    line_d   = tick && (hc_d == '0);
    frame_d  = line_d && (vc_d == '0);
  end

  // Divider and position counters; reset parks on the last pixel so the
  // first edge after release is a tick landing on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_LAST;
      hc_q  <= H_LAST;
      vc_q  <= V_LAST;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  // Registered outputs: levels update only on a tick, strobes every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync_q  <= ~H_SYNC_POL;
      v_sync_q  <= ~V_SYNC_POL;
      blank_q   <= 1'b0;
      posx_q    <= '0;
      posy_q    <= '0;
      pix_stb_q <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      pix_stb_q <= tick;
      line_q    <= line_d;
      frame_q   <= frame_d;
      if (tick) begin
        h_sync_q <= h_sync_d;
        v_sync_q <= v_sync_d;
        blank_q  <= blank_d;
        posx_q   <= posx_d;
        posy_q   <= posy_d;
      end
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign blank_n     = blank_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign pix_stb     = pix_stb_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of vga_timing_gen in four configurations: defaults,
// default line with a short vertical (so whole frames stay cheap), a tiny
// PIX_DIV=1 positive-polarity mode and a tiny PIX_DIV=3 mode.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_def = 1'b1, rst_mv = 1'b1, rst_sm = 1'b1, rst_d3 = 1'b1;

  logic def_h, def_v, def_b, def_stb, def_ls, def_fs;
  logic [10:0] def_x, def_y;
  logic mv_h, mv_v, mv_b, mv_stb, mv_ls, mv_fs;
  logic [10:0] mv_x, mv_y;
  logic sm_h, sm_v, sm_b, sm_stb, sm_ls, sm_fs;
  logic [2:0] sm_x, sm_y;
  logic d3_h, d3_v, d3_b, d3_stb, d3_ls, d3_fs;
  logic [3:0] d3_x, d3_y;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_def), .h_sync(def_h), .v_sync(def_v), .blank_n(def_b),
    .posx(def_x), .posy(def_y), .pix_stb(def_stb), .line_start(def_ls), .frame_start(def_fs));

  vga_timing_gen #(.V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_mv (
    .clk(clk), .rst(rst_mv), .h_sync(mv_h), .v_sync(mv_v), .blank_n(mv_b),
    .posx(mv_x), .posy(mv_y), .pix_stb(mv_stb), .line_start(mv_ls), .frame_start(mv_fs));

  // H_TOTAL=8 with CW=3 sits exactly at the 2^CW limit
  vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1), .CW(3)) u_sm (
    .clk(clk), .rst(rst_sm), .h_sync(sm_h), .v_sync(sm_v), .blank_n(sm_b),
    .posx(sm_x), .posy(sm_y), .pix_stb(sm_stb), .line_start(sm_ls), .frame_start(sm_fs));

  vga_timing_gen #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .PIX_DIV(3), .CW(4)) u_d3 (
    .clk(clk), .rst(rst_d3), .h_sync(d3_h), .v_sync(d3_v), .blank_n(d3_b),
    .posx(d3_x), .posy(d3_y), .pix_stb(d3_stb), .line_start(d3_ls), .frame_start(d3_fs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, fall, lowcnt, vbad, vlow, vfall, ffirst, p, hc, vc;
    logic vprev, eh, ev, eb;
    logic [2:0] ex3, ey3;
    logic [3:0] ex4, ey4;

    // ---------------- reset state ----------------
    #12;
    chk("def_reset", {def_h, def_v, def_b, def_x, def_y, def_stb, def_ls, def_fs},
        {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0});
    chk("sm_reset", {sm_h, sm_v, sm_b, sm_x, sm_y, sm_stb, sm_ls, sm_fs},
        {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});

    // ---------------- defaults: first frame ----------------
    @(negedge clk) rst_def = 1'b0;
    step();
    chk("def_first", {def_fs, def_ls, def_stb, def_b, def_x, def_y, def_h, def_v},
        {1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 1'b1});
    step();
    chk("def_hold", {def_stb, def_fs, def_b, def_x}, {1'b0, 1'b0, 1'b1, 11'd0});
    step();
    chk("def_px1", {def_stb, def_ls, def_x}, {1'b1, 1'b0, 11'd1});
    n = 2;
    do begin step(); n++; end while (!def_ls && n < 2000);
    chk("def_line_period", n, 1600);

    // ---------------- defaults: horizontal ----------------
    fall = -1; lowcnt = 0;
    for (int i = 1; i <= 1600; i++) begin
      step();
      if (!def_h) begin
        lowcnt++;
        if (fall < 0) begin
          fall = i;
          chk("def_hfall_stb", def_stb, 1'b1);
        end
      end
      if (i == 1278) chk("def_x639", {def_b, def_x}, {1'b1, 11'd639});
      if (i == 1280) chk("def_x640", {def_b, def_x}, {1'b0, 11'd0});
    end
    chk("def_hfall_at", fall, 1312);
    chk("def_hlow_len", lowcnt, 192);
    chk("def_line2", {def_ls, def_fs, def_v}, {1'b1, 1'b0, 1'b1});

    // ---------------- defaults: reset inside h_sync ----------------
    for (int i = 1; i <= 1400; i++) step();
    chk("def_pre_rst_hs", def_h, 1'b0);
    #2 rst_def = 1'b1;
    #1;
    chk("def_async_rst", {def_h, def_v, def_b, def_x, def_y, def_stb},
        {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0});
    @(negedge clk) rst_def = 1'b0;
    step();
    chk("def_rerun_first", {def_fs, def_ls, def_stb, def_b, def_x, def_y, def_h, def_v},
        {1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 1'b1});
    n = 0;
    do begin step(); n++; end while (!def_ls && n < 2000);
    chk("def_rerun_line_period", n, 1600);

    // ---------------- default line, short vertical (8 lines) ----------------
    @(negedge clk) rst_mv = 1'b0;
    step();
    chk("mv_first", {mv_fs, mv_b, mv_y}, {1'b1, 1'b1, 11'd0});
    vprev = mv_v; vbad = 0; vlow = 0; vfall = -1; ffirst = -1;
    for (int i = 1; i <= 12800; i++) begin
      step();
      if (mv_v !== vprev && !mv_ls) vbad++;
      vprev = mv_v;
      if (!mv_v) begin
        vlow++;
        if (vfall < 0) vfall = i;
      end
      if (mv_fs && ffirst < 0) ffirst = i;
      if (i == 4800) chk("mv_lastrow", {mv_b, mv_y}, {1'b1, 11'd3});
      if (i == 6400) chk("mv_row4", {mv_b, mv_y, mv_ls}, {1'b0, 11'd0, 1'b1});
    end
    chk("mv_vsync_on_ls", vbad, 0);
    chk("mv_vlow_len", vlow, 3200);
    chk("mv_vfall_at", vfall, 8000);
    chk("mv_frame_period", ffirst, 12800);

    // ---------------- tiny mode, PIX_DIV=1, active-high syncs ----------------
    @(negedge clk) rst_sm = 1'b0;
    for (int k = 0; k < 144; k++) begin
      step();
      p = k % 48; hc = p % 8; vc = p / 8;
      eh = (hc == 5 || hc == 6);
      ev = (vc == 4);
      eb = (hc < 4 && vc < 3);
      ex3 = eb ? 3'(hc) : 3'd0;
      ey3 = eb ? 3'(vc) : 3'd0;
      chk($sformatf("sm_k%0d", k), {sm_h, sm_v, sm_b, sm_x, sm_y, sm_stb, sm_ls, sm_fs},
          {eh, ev, eb, ex3, ey3, 1'b1, (hc == 0), (p == 0)});
    end

    // ---------------- tiny mode, PIX_DIV=3 ----------------
    @(negedge clk) rst_d3 = 1'b0;
    for (int k = 0; k < 144; k++) begin
      step();
      p = (k / 3) % 48; hc = p % 8; vc = p / 8;
      eh = !(hc == 5 || hc == 6);
      ev = !(vc == 4);
      eb = (hc < 4 && vc < 3);
      ex4 = eb ? 4'(hc) : 4'd0;
      ey4 = eb ? 4'(vc) : 4'd0;
      chk($sformatf("d3_k%0d", k), {d3_h, d3_v, d3_b, d3_x, d3_y, d3_stb, d3_ls, d3_fs},
          {eh, ev, eb, ex4, ey4, (k % 3 == 0), (k % 3 == 0 && hc == 0), (k % 3 == 0 && p == 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/VESA raster timing generator; successor to the fixed 640x480 controller.
- Timing, sync polarity and pixel-clock division are set by parameters, so one block covers 640x480@60, 800x600 and small simulation modes.
- Produces registered, skew-free syncs, blanking, pixel coordinates, a pixel strobe and line/frame start pulses.
- Sits between the system clock and the framebuffer/character-render logic in the display path.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync
PIX_DIV, 2, system clocks per pixel (>= 1)
CW, 11, counter/coordinate width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
h_sync  out  1  horizontal sync at H_SYNC_POL when asserted
v_sync  out  1  vertical sync at V_SYNC_POL when asserted
blank_n  out  1  1 inside the active area
posx  out  CW  active-area x coordinate, 0 outside the active area
posy  out  CW  active-area y coordinate, 0 outside the active area
pix_stb  out  1  one-clock pulse: outputs now describe a new pixel
line_start  out  1  one-clock pulse with pix_stb when hcount==0
frame_start  out  1  one-clock pulse with pix_stb when hcount==0 and vcount==0

Behaviour:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Elaboration error if any timing parameter is 0, if PIX_DIV < 1, or if H_TOTAL or V_TOTAL > 2^CW.
- Line order: display [0,H_DISPLAY), front porch, sync, back porch. Vertical order is the same.
- Divider: div counts 0..PIX_DIV-1 and wraps. tick = (div==PIX_DIV-1). With PIX_DIV=1, tick is 1 every clock.
- Counters: on tick, hcount advances by 1. When hcount==H_TOTAL-1, hcount wraps to 0 and vcount advances. vcount wraps from V_TOTAL-1 to 0 at that same edge.
- Outputs are registered and update on the same tick edge as the counters, computed from the next position (no counter/output skew). Between ticks all outputs hold, except the pulses.
- Decode of position (hc, vc):
  - blank_n = hc<H_DISPLAY && vc<V_DISPLAY
  - posx = blank_n ? hc : 0
  - posy = blank_n ? vc : 0
  - h_sync = H_SYNC_POL when H_DISPLAY+H_FRONT <= hc < H_DISPLAY+H_FRONT+H_SYNC, else ~H_SYNC_POL
  - v_sync is the same rule on vc. It therefore changes only on edges where hc becomes 0.
- pix_stb: registered copy of tick, high exactly one clock per pixel period, in the first clock of the new position.
- line_start and frame_start are 1 only in that pix_stb clock.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - div = PIX_DIV-1, hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL, blank_n = 0, posx = posy = 0.
  - pix_stb = line_start = frame_start = 0.
- After reset release, the first clock edge is a tick and moves to (0,0). Result: pix_stb = line_start = frame_start = 1 and blank_n = 1 in the first cycle, with no partial first frame.
- Steady state: frame_start period is exactly H_TOTAL*V_TOTAL*PIX_DIV clocks. line_start period is H_TOTAL*PIX_DIV clocks.

Test Plan:
- Defaults, release reset:
  - the cycle after the first edge shows frame_start=1, posx=0, posy=0, blank_n=1.
  - the next frame_start comes exactly 840000 clocks later.
  - line_start spacing is 1600 clocks.
- Defaults, horizontal:
  - h_sync falls on the edge where hcount becomes 656 and stays low 96 pixel periods (192 clocks).
  - posx=639 is followed by blank_n=0, posx=0.
- Defaults, vertical:
  - v_sync is low for exactly lines 490-491 (2*1600 clocks).
  - v_sync changes only in cycles where line_start=1.
  - posy=479 is followed by posy=0 with blank_n=0 on line 480.
- Small mode (H 4/1/2/1, V 3/1/1/1, PIX_DIV=1, both polarities 1), compared against a reference model over 3 frames:
  - total 8x6=48 clocks per frame.
  - h_sync is high at hc 5-6 only.
  - pix_stb is constantly 1.
- Reset mid-h_sync (defaults): assert rst asynchronously between clock edges.
  - outputs go to reset values immediately: h_sync=1, blank_n=0.
  - after release, the first-frame sequence is identical to scenario 1.
- PIX_DIV=3: all outputs hold for 3 clocks; pix_stb pulses every 3rd clock, aligned with coordinate changes.
